// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, one-hot ALU, data SRAM drive and an
// iterative restoring divider for DIV/DIVU that stalls the front of the pipe.
module ex_stage #(
   parameter int unsigned ID_TO_EX_WD  = 159,
   parameter int unsigned EX_TO_MEM_WD = 142,
   parameter int unsigned EX_TO_RF_WD  = 38,
   parameter int unsigned StallBus     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [StallBus-1:0]     stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   output logic                    stallreq_for_ex
);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } div_state_e;

   // ------------------------------------------------------------------
   // ID/EX register
   // ------------------------------------------------------------------
   logic [ID_TO_EX_WD-1:0] id_ex_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_ex_q <= '0;
      end else if (stall[2] && !stall[3]) begin
         id_ex_q <= '0;
      end else if (!stall[2]) begin
         id_ex_q <= id_to_ex_bus;
      end
   end

   logic [31:0] pc;
   logic [31:0] inst;
   logic [11:0] alu_op;
   logic [2:0]  sel_alu_src1;
   logic [3:0]  sel_alu_src2;
   logic        data_ram_en;
   logic [3:0]  data_ram_wen;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic        sel_rf_res;
   logic [31:0] rdata1;
   logic [31:0] rdata2;

   assign pc           = id_ex_q[158:127];
   assign inst         = id_ex_q[126:95];
   assign alu_op       = id_ex_q[94:83];
   assign sel_alu_src1 = id_ex_q[82:80];
   assign sel_alu_src2 = id_ex_q[79:76];
   assign data_ram_en  = id_ex_q[75];
   assign data_ram_wen = id_ex_q[74:71];
   assign rf_we        = id_ex_q[70];
   assign rf_waddr     = id_ex_q[69:65];
   assign sel_rf_res   = id_ex_q[64];
   assign rdata1       = id_ex_q[63:32];
   assign rdata2       = id_ex_q[31:0];

   // ------------------------------------------------------------------
   // Operand selection
   // ------------------------------------------------------------------
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic [31:0] op1;
   logic [31:0] op2;

   assign imm_sext = {{16{inst[15]}}, inst[15:0]};
   assign imm_zext = {16'h0000, inst[15:0]};

   assign op1 = ({32{sel_alu_src1[0]}} & rdata1)
              | ({32{sel_alu_src1[1]}} & pc)
              | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});

   assign op2 = ({32{sel_alu_src2[0]}} & rdata2)
              | ({32{sel_alu_src2[1]}} & imm_sext)
              | ({32{sel_alu_src2[2]}} & 32'd8)
              | ({32{sel_alu_src2[3]}} & imm_zext);

   // ------------------------------------------------------------------
   // ALU (one-hot op, AND-OR merged results)
   // ------------------------------------------------------------------
   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic        slt_res;
   logic        sltu_res;
   logic [4:0]  shamt;
   logic [31:0] sra_res;
   logic [31:0] ex_result;

   assign add_res  = op1 + op2;
   assign sub_res  = op1 - op2;
   assign slt_res  = $signed(op1) < $signed(op2);
   assign sltu_res = op1 < op2;
   assign shamt    = op1[4:0];
   assign sra_res  = $signed(op2) >>> shamt;

   always_comb begin
      ex_result = '0;
      if (alu_op[11]) ex_result = ex_result | add_res;
      if (alu_op[10]) ex_result = ex_result | sub_res;
      if (alu_op[9])  ex_result = ex_result | {31'b0, slt_res};
      if (alu_op[8])  ex_result = ex_result | {31'b0, sltu_res};
      if (alu_op[7])  ex_result = ex_result | (op1 & op2);
      if (alu_op[6])  ex_result = ex_result | ~(op1 | op2);
      if (alu_op[5])  ex_result = ex_result | (op1 | op2);
      if (alu_op[4])  ex_result = ex_result | (op1 ^ op2);
      if (alu_op[3])  ex_result = ex_result | (op2 << shamt);
      if (alu_op[2])  ex_result = ex_result | (op2 >> shamt);
      if (alu_op[1])  ex_result = ex_result | sra_res;
      if (alu_op[0])  ex_result = ex_result | {inst[15:0], 16'h0000};
   end

   // ------------------------------------------------------------------
   // Divider decode and operand magnitudes
   // ------------------------------------------------------------------
   logic        is_div;
   logic        is_signed;
   logic        dvd_neg;
   logic        dvs_neg;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;

   assign is_div    = (inst[31:26] == 6'h00) && ((inst[5:0] == 6'h1A) || (inst[5:0] == 6'h1B));
   assign is_signed = (inst[5:0] == 6'h1A);
   assign dvd_neg   = is_signed && rdata1[31];
   assign dvs_neg   = is_signed && rdata2[31];
   assign dvd_mag   = dvd_neg ? (32'd0 - rdata1) : rdata1;
   assign dvs_mag   = dvs_neg ? (32'd0 - rdata2) : rdata2;

   div_state_e  state_q;
   logic [5:0]  cnt_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   // One restoring step: shift the next dividend bit (quotient MSB) into the
   // partial remainder and subtract the divisor when it fits.
   logic [32:0] trial;
   logic [32:0] trial_diff;
   logic        fits;
   logic [31:0] step_rem;
   logic [31:0] step_quo;
   logic [31:0] fix_rem;
   logic [31:0] fix_quo;

   assign trial      = {rem_q, quo_q[31]};
   assign trial_diff = trial - {1'b0, dvs_q};
   assign fits       = !trial_diff[32];
   assign step_rem   = fits ? trial_diff[31:0] : trial[31:0];
   assign step_quo   = {quo_q[30:0], fits};
   assign fix_rem    = neg_rem_q ? (32'd0 - step_rem) : step_rem;
   assign fix_quo    = neg_quo_q ? (32'd0 - step_quo) : step_quo;

   // ------------------------------------------------------------------
   // Divider FSM and datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (is_div) begin
                  if (rdata2 == 32'd0) begin
                     hi_q    <= rdata1;
                     lo_q    <= 32'hFFFF_FFFF;
                     state_q <= StDone;
                  end else begin
                     rem_q     <= '0;
                     quo_q     <= dvd_mag;
                     dvs_q     <= dvs_mag;
                     neg_quo_q <= dvd_neg ^ dvs_neg;
                     neg_rem_q <= dvd_neg;
                     cnt_q     <= '0;
                     state_q   <= StBusy;
                  end
               end
            end
            StBusy: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  hi_q    <= fix_rem;
                  lo_q    <= fix_quo;
                  state_q <= StDone;
               end
            end
            StDone: begin
               // With stall[3] low the ID/EX register always takes new contents.
               if (!stall[3]) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   logic        div_done;
   logic [31:0] hi;
   logic [31:0] lo;

   assign div_done = (state_q == StDone);
   assign hi       = div_done ? hi_q : 32'd0;
   assign lo       = div_done ? lo_q : 32'd0;

   assign stallreq_for_ex = ((state_q == StIdle) && is_div) || (state_q == StBusy);

   assign ex_to_mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr,
                           ex_result, div_done, div_done, hi, lo};
   assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

   assign data_sram_en    = data_ram_en;
   assign data_sram_wen   = data_ram_wen;
   assign data_sram_addr  = ex_result;
   assign data_sram_wdata = rdata2;

   logic unused_bits;
   assign unused_bits = ^{stall[StallBus-1:4], stall[1:0], inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed ALU vectors, stall/bubble behaviour, divider
// sequences, reset abort and random ALU/divide traffic against a reference model.
module tb_ex_stage;

   logic         clk;
   logic         rst;
   logic [5:0]   stall;
   logic [158:0] id_to_ex_bus;
   logic [141:0] ex_to_mem_bus;
   logic [37:0]  ex_to_rf_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic         stallreq_for_ex;

   int total = 0;
   int bad   = 0;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .id_to_ex_bus    (id_to_ex_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_rf_bus    (ex_to_rf_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .stallreq_for_ex (stallreq_for_ex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] op;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic        en;
      logic [3:0]  wen;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [141:0] act, input logic [141:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [158:0] mk_bus(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic [11:0] op, input logic [2:0] s1,
                                           input logic [3:0] s2, input logic en,
                                           input logic [3:0] wen, input logic we,
                                           input logic [4:0] wa, input logic [31:0] rd1,
                                           input logic [31:0] rd2);
      return {pc, inst, op, s1, s2, en, wen, we, wa, 1'b0, rd1, rd2};
   endfunction

   function automatic logic [141:0] mk_mem(input logic [31:0] pc, input logic en,
                                           input logic [3:0] wen, input logic we,
                                           input logic [4:0] wa, input logic [31:0] res,
                                           input logic hilo_we, input logic [31:0] hi,
                                           input logic [31:0] lo);
      return {pc, en, wen, 1'b0, we, wa, res, hilo_we, hilo_we, hi, lo};
   endfunction

   // Reference ALU written from the operation list, not the datapath structure.
   function automatic logic [31:0] ref_alu(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic [11:0] op, input logic [2:0] s1,
                                           input logic [3:0] s2, input logic [31:0] ra,
                                           input logic [31:0] rb);
      logic [31:0] x;
      logic [31:0] y;
      int          sh;
      x = 32'd0;
      y = 32'd0;
      if (s1 == 3'b001) x = ra;
      else if (s1 == 3'b010) x = pc;
      else if (s1 == 3'b100) x = {27'd0, inst[10:6]};
      case (s2)
         4'b0001: y = rb;
         4'b0010: y = {{16{inst[15]}}, inst[15:0]};
         4'b0100: y = 32'd8;
         4'b1000: y = {16'd0, inst[15:0]};
         default: y = 32'd0;
      endcase
      sh = int'(x % 32);
      case (op)
         12'h800: return x + y;
         12'h400: return x - y;
         12'h200: return (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
         12'h100: return (x < y) ? 32'd1 : 32'd0;
         12'h080: return x & y;
         12'h040: return ~(x | y);
         12'h020: return x | y;
         12'h010: return x ^ y;
         12'h008: return y << sh;
         12'h004: return y >> sh;
         12'h002: return 32'(longint'($signed(y)) / (longint'(1) << sh)
                             - ((y[31] && (y % (32'd1 << sh)) != 0) ? 1 : 0));
         12'h001: return {inst[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   task automatic div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else if (!sgn) begin
         lo = a / b;
         hi = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lo = 32'(sa / sb);
         hi = 32'(sa % sb);
      end
   endtask

   task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
      logic [31:0] eh;
      logic [31:0] el;
      logic [31:0] pcv;
      int          n;
      div_ref(sgn, a, b, eh, el);
      pcv = 32'hBFC0_0100;
      id_to_ex_bus = mk_bus(pcv, {6'h00, 5'd4, 5'd5, 10'd0, sgn ? 6'h1A : 6'h1B}, 12'h000,
                            3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, a, b);
      stall = 6'b000000;
      tick();
      stall = 6'b001111;
      id_to_ex_bus = mk_bus(32'h1234, 32'h3423_0F0F, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0,
                            1'b1, 5'd3, 32'hF0, 32'h0);
      n = 0;
      while (stallreq_for_ex === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      chk({name, " stall cycles"}, 142'(n), (b == 32'd0) ? 142'd1 : 142'd33);
      chk({name, " result"}, ex_to_mem_bus, mk_mem(pcv, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0, 1'b1,
                                                  eh, el));
      tick();
      chk({name, " held in done"}, {141'(ex_to_mem_bus), stallreq_for_ex},
          {141'(mk_mem(pcv, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0, 1'b1, eh, el)), 1'b0});
      stall = 6'b000000;
      id_to_ex_bus = '0;
      tick();
      chk({name, " retire"}, ex_to_mem_bus, 142'd0);
   endtask

   initial begin
      logic [31:0]  exp_res;
      logic [158:0] ori_bus;
      logic [141:0] ori_mem;
      int           pulses;

      // {name, pc, inst, op, s1, s2, en, wen, we, wa, rd1, rd2, exp}
      vecs.push_back('{"addiu", 32'h100, 32'h2422_0001, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0,
                       1'b1, 5'd2, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000});
      vecs.push_back('{"ori", 32'h104, 32'h3423_0F0F, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0,
                       1'b1, 5'd3, 32'h0000_00F0, 32'h0, 32'h0000_0FFF});
      vecs.push_back('{"subu", 32'h108, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd4, 32'd5, 32'd7, 32'hFFFF_FFFE});
      vecs.push_back('{"slt", 32'h10C, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd1});
      vecs.push_back('{"sltu", 32'h110, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0});
      vecs.push_back('{"and", 32'h114, 32'h0, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200});
      vecs.push_back('{"nor", 32'h118, 32'h0, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd8, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00});
      vecs.push_back('{"xor", 32'h11C, 32'h0, 12'h010, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd9, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555});
      vecs.push_back('{"sll", 32'h120, 32'h0000_0100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd10, 32'h0, 32'h0000_00F1, 32'h0000_0F10});
      vecs.push_back('{"srlv", 32'h124, 32'h0, 12'h004, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd11, 32'h24, 32'h8000_0000, 32'h0800_0000});
      vecs.push_back('{"srav", 32'h128, 32'h0, 12'h002, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b1, 5'd12, 32'h24, 32'h8000_0000, 32'hF800_0000});
      vecs.push_back('{"lui", 32'h12C, 32'h3C04_BEEF, 12'h001, 3'b000, 4'b0000, 1'b0, 4'h0,
                       1'b1, 5'd4, 32'h0, 32'h0, 32'hBEEF_0000});
      vecs.push_back('{"jal link", 32'hBFC0_0010, 32'h0, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0,
                       1'b1, 5'd31, 32'h0, 32'h0, 32'hBFC0_0018});
      vecs.push_back('{"no op", 32'h130, 32'h0, 12'h000, 3'b001, 4'b0001, 1'b0, 4'h0,
                       1'b0, 5'd0, 32'd123, 32'd456, 32'd0});
      vecs.push_back('{"sw addr", 32'h134, 32'hAC22_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF,
                       1'b0, 5'd2, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0FFC});

      // Reset state
      rst = 1'b0;
      stall = 6'b000000;
      id_to_ex_bus = '0;
      #3;
      chk("reset mem bus", ex_to_mem_bus, 142'd0);
      chk("reset other outputs", 142'({ex_to_rf_bus, data_sram_en, data_sram_wen,
                                       data_sram_addr, data_sram_wdata, stallreq_for_ex}),
          142'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      chk("post reset idle", 142'({ex_to_mem_bus, stallreq_for_ex}), 142'd0);

      // Directed ALU vectors
      foreach (vecs[i]) begin
         id_to_ex_bus = mk_bus(vecs[i].pc, vecs[i].inst, vecs[i].op, vecs[i].s1, vecs[i].s2,
                               vecs[i].en, vecs[i].wen, vecs[i].we, vecs[i].wa, vecs[i].rd1,
                               vecs[i].rd2);
         stall = 6'b000000;
         tick();
         chk({vecs[i].name, " mem bus"}, ex_to_mem_bus,
             mk_mem(vecs[i].pc, vecs[i].en, vecs[i].wen, vecs[i].we, vecs[i].wa, vecs[i].exp,
                    1'b0, 32'd0, 32'd0));
         chk({vecs[i].name, " rf bus"}, 142'(ex_to_rf_bus),
             142'({vecs[i].we, vecs[i].wa, vecs[i].exp}));
         chk({vecs[i].name, " sram"}, 142'({data_sram_en, data_sram_wen, data_sram_addr,
                                           data_sram_wdata, stallreq_for_ex}),
             142'({vecs[i].en, vecs[i].wen, vecs[i].exp, vecs[i].rd2, 1'b0}));
      end

      // Bubble and hold
      ori_bus = mk_bus(32'h200, 32'h3423_0F0F, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1,
                       5'd3, 32'hF0, 32'h0);
      ori_mem = mk_mem(32'h200, 1'b0, 4'h0, 1'b1, 5'd3, 32'h0FFF, 1'b0, 32'd0, 32'd0);
      id_to_ex_bus = ori_bus;
      tick();
      stall = 6'b000111;
      id_to_ex_bus = mk_bus(32'h300, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9,
                            32'd1, 32'd2);
      tick();
      chk("bubble mem bus", ex_to_mem_bus, 142'd0);
      chk("bubble rf bus", 142'(ex_to_rf_bus), 142'd0);
      stall = 6'b000000;
      id_to_ex_bus = ori_bus;
      tick();
      stall = 6'b001111;
      id_to_ex_bus = mk_bus(32'h300, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9,
                            32'd1, 32'd2);
      tick();
      chk("hold 1", ex_to_mem_bus, ori_mem);
      tick();
      chk("hold 2", ex_to_mem_bus, ori_mem);
      stall = 6'b000000;

      // Directed divides
      run_div("divu 100/7", 1'b0, 32'd100, 32'd7);
      run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("div by 0", 1'b1, 32'h1234_5678, 32'd0);
      run_div("divu by 0", 1'b0, 32'hDEAD_BEEF, 32'd0);
      run_div("divu max/16", 1'b0, 32'hFFFF_FFFF, 32'h10);

      // Random divides
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
         if (b == 32'd0) b = 32'd3;
         run_div($sformatf("rand div %0d", i), 1'($urandom_range(0, 1)), a, b);
      end

      // Random ALU traffic
      for (int i = 0; i < 200; i++) begin
         logic [31:0] pcv;
         logic [31:0] inst;
         logic [11:0] op;
         logic [2:0]  s1;
         logic [3:0]  s2;
         logic [31:0] ra;
         logic [31:0] rb;
         logic [4:0]  wa;
         int          k;
         pcv = $urandom;
         inst = $urandom;
         inst[31:26] = 6'($urandom_range(1, 63));
         k = $urandom_range(0, 12);
         op = (k == 12) ? 12'h000 : (12'h001 << k);
         s1 = 3'b001 << $urandom_range(0, 2);
         s2 = 4'b0001 << $urandom_range(0, 3);
         ra = $urandom;
         rb = $urandom;
         wa = 5'($urandom);
         exp_res = ref_alu(pcv, inst, op, s1, s2, ra, rb);
         id_to_ex_bus = mk_bus(pcv, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, wa, ra, rb);
         tick();
         chk($sformatf("rand alu %0d op %h", i, op), 142'({ex_to_rf_bus, data_sram_wdata,
                                                         stallreq_for_ex}),
             142'({1'b1, wa, exp_res, rb, 1'b0}));
      end

      // Reset in the middle of a divide
      id_to_ex_bus = mk_bus(32'h400, {6'h00, 5'd4, 5'd5, 10'd0, 6'h1B}, 12'h000, 3'b000,
                            4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd3);
      stall = 6'b000000;
      tick();
      stall = 6'b001111;
      repeat (11) tick();
      chk("busy before abort", 142'(stallreq_for_ex), 142'd1);
      rst = 1'b0;
      #1;
      chk("abort stallreq", 142'(stallreq_for_ex), 142'd0);
      chk("abort mem bus", ex_to_mem_bus, 142'd0);
      chk("abort other outputs", 142'({ex_to_rf_bus, data_sram_en, data_sram_wen,
                                       data_sram_addr, data_sram_wdata}), 142'd0);
      stall = 6'b000000;
      id_to_ex_bus = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (40) begin
         tick();
         if (ex_to_mem_bus[65] || ex_to_mem_bus[64] || stallreq_for_ex) pulses++;
      end
      chk("no hilo after abort", 142'(pulses), 142'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
